led_ctrl_ipc: RTL and testbench

LED_CTRL_IPC -- requirements
Module: led_ctrl_ipc

---
 rtl/led_ctrl_ipc.sv | 273 +++++++++++++++++++++++++++
 tb/tb_led_ctrl_ipc.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_ctrl_ipc.sv
// led_ctrl_ipc: LED controller driven by tokenised IPC command messages.
//
// Reads tokens from a command FIFO, parses "led" TARGET ARG EOM messages,
// stages the result in shadow registers, commits on EOM, and returns a
// numeric response token (0 OK, 1 syntax error, 2 range error).
//
// Ports:
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   LED          - LED drive, bit n-1 is LED n
//   FIFO_DATA    - token, valid the cycle after FIFO_RD_EN
//   FIFO_RD_EN   - one-cycle read strobe
//   FIFO_EMPTY   - command FIFO empty
//   RSP_DATA     - response token (numeric)
//   RSP_VALID    - response valid, held until RSP_READY
//   RSP_READY    - response accepted
//
// state      | meaning
// IDLE       | clear shadows, start first token read
// FETCH      | issue read strobe for next token
// CAPTURE    | strobe high, token arrives next cycle
// CMD        | expect "led" (EOM here drops the message silently)
// TARGET     | expect "all" or LED number
// ARG        | expect "on", "off", "dim" or blink divisor
// LEVEL      | expect dim level
// EXPECT_EOM | expect EOM, commit shadows
// FLUSH      | discard tokens through EOM after an error
// RESPOND    | present response until accepted

`ifndef IPC_TOKEN_WIDTH
`define IPC_TOKEN_WIDTH 65
`endif

module led_ctrl_ipc #(
  parameter int LED_COUNT   = 16,
  parameter int CLOCK_FREQ  = 100000000,
  parameter int DIVISORS    = 20,
  parameter int PWM_BITS    = 4,
  parameter int TOKEN_WIDTH = `IPC_TOKEN_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [LED_COUNT-1:0]   LED,
  input  logic [TOKEN_WIDTH-1:0] FIFO_DATA,
  output logic                   FIFO_RD_EN,
  input  logic                   FIFO_EMPTY,
  output logic [TOKEN_WIDTH-1:0] RSP_DATA,
  output logic                   RSP_VALID,
  input  logic                   RSP_READY
);

  localparam int VW = TOKEN_WIDTH - 1;
  localparam int IW = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
  localparam int DW = $clog2(DIVISORS + 1);
  localparam int CW = $clog2(CLOCK_FREQ + 1);

  // Alpha words are ASCII, right-aligned and zero-filled.
  localparam logic [TOKEN_WIDTH-1:0] W_LED = TOKEN_WIDTH'(24'h6c6564);
  localparam logic [TOKEN_WIDTH-1:0] W_ALL = TOKEN_WIDTH'(24'h616c6c);
  localparam logic [TOKEN_WIDTH-1:0] W_ON  = TOKEN_WIDTH'(16'h6f6e);
  localparam logic [TOKEN_WIDTH-1:0] W_OFF = TOKEN_WIDTH'(24'h6f6666);
  localparam logic [TOKEN_WIDTH-1:0] W_DIM = TOKEN_WIDTH'(24'h64696d);

  localparam logic [VW-1:0] ONE     = VW'(1);
  localparam logic [VW-1:0] LED_MAX = VW'(LED_COUNT);
  localparam logic [VW-1:0] DIV_MAX = VW'(DIVISORS);
  localparam logic [VW-1:0] LVL_MAX = VW'((1 << PWM_BITS) - 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, CAPTURE, CMD, TARGET, ARG, LEVEL, EXPECT_EOM, FLUSH, RESPOND
  } state_t;

  typedef enum logic [1:0] {FIXED_OFF, FIXED_ON, BLINK, DIM} mode_t;

  state_t state, phase, pnext;
  logic [1:0] perr;
  logic [1:0] code;

  logic                sh_all;
  logic [IW-1:0]       sh_idx;
  mode_t               sh_mode;
  logic [DW-1:0]       sh_div;
  logic [PWM_BITS-1:0] sh_level;

  logic          tok_num, tok_eom, commit;
  logic [VW-1:0] tok_val;

  assign tok_num = FIFO_DATA[TOKEN_WIDTH-1];
  assign tok_eom = (FIFO_DATA == '0);
  assign tok_val = FIFO_DATA[VW-1:0];
  assign commit  = (state == EXPECT_EOM) && tok_eom;

  // Half-period reload values, one per legal divisor, fixed at elaboration.
  logic [CW-1:0] reload_tbl [DIVISORS+1];
  assign reload_tbl[0] = '0;
  for (genvar d = 1; d <= DIVISORS; d++) begin : g_reload
    localparam int HALF = CLOCK_FREQ / d;
    assign reload_tbl[d] = (HALF > 0) ? CW'(HALF - 1) : '0;
  end

  // Token classification for the token-consuming states.
  always_comb begin
    perr  = 2'd0;
    pnext = state;
    case (state)
      CMD: begin
        if (tok_eom)                 pnext = IDLE;
        else if (FIFO_DATA == W_LED) pnext = TARGET;
        else                         perr  = 2'd1;
      end
      TARGET: begin
        if (FIFO_DATA == W_ALL) pnext = ARG;
        else if (tok_num) begin
          if (tok_val >= ONE && tok_val <= LED_MAX) pnext = ARG;
          else                                      perr  = 2'd2;
        end else perr = 2'd1;
      end
      ARG: begin
        if (FIFO_DATA == W_ON || FIFO_DATA == W_OFF) pnext = EXPECT_EOM;
        else if (FIFO_DATA == W_DIM)                 pnext = LEVEL;
        else if (tok_num) begin
          if (tok_val >= ONE && tok_val <= DIV_MAX) pnext = EXPECT_EOM;
          else                                      perr  = 2'd2;
        end else perr = 2'd1;
      end
      LEVEL: begin
        if (tok_num) begin
          if (tok_val <= LVL_MAX) pnext = EXPECT_EOM;
          else                    perr  = 2'd2;
        end else perr = 2'd1;
      end
      EXPECT_EOM: begin
        if (tok_eom) pnext = RESPOND;
        else         perr  = 2'd1;
      end
      FLUSH: begin
        if (tok_eom) pnext = RESPOND;
      end
      default: ;
    endcase
    // An error token that is itself EOM ends the message already.
    if (perr != 2'd0) pnext = tok_eom ? RESPOND : FLUSH;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      phase      <= CMD;
      FIFO_RD_EN <= 1'b0;
      RSP_VALID  <= 1'b0;
      RSP_DATA   <= '0;
      code       <= '0;
      sh_all     <= 1'b0;
      sh_idx     <= '0;
      sh_mode    <= FIXED_OFF;
      sh_div     <= '0;
      sh_level   <= '0;
    end else begin
      case (state)
        IDLE: begin
          code     <= '0;
          sh_all   <= 1'b0;
          sh_idx   <= '0;
          sh_mode  <= FIXED_OFF;
          sh_div   <= '0;
          sh_level <= '0;
          if (!FIFO_EMPTY) begin
            FIFO_RD_EN <= 1'b1;
            phase      <= CMD;
            state      <= CAPTURE;
          end
        end
        FETCH: begin
          if (!FIFO_EMPTY) begin
            FIFO_RD_EN <= 1'b1;
            state      <= CAPTURE;
          end
        end
        CAPTURE: begin
          FIFO_RD_EN <= 1'b0;
          state      <= phase;
        end
        CMD, TARGET, ARG, LEVEL, EXPECT_EOM, FLUSH: begin
          case (state)
            TARGET: begin
              sh_all <= (FIFO_DATA == W_ALL);
              sh_idx <= IW'(tok_val - ONE);
            end
            ARG: begin
              if (FIFO_DATA == W_ON)       sh_mode <= FIXED_ON;
              else if (FIFO_DATA == W_OFF) sh_mode <= FIXED_OFF;
              else if (FIFO_DATA == W_DIM) sh_mode <= DIM;
              else begin
                sh_mode <= BLINK;
                sh_div  <= DW'(tok_val);
              end
            end
            LEVEL:   sh_level <= PWM_BITS'(tok_val);
            default: ;
          endcase
          if (perr != 2'd0) code <= perr;
          if (pnext == IDLE || pnext == RESPOND) state <= pnext;
          else begin
            phase <= pnext;
            state <= FETCH;
          end
        end
        RESPOND: begin
          if (!RSP_VALID) begin
            RSP_VALID <= 1'b1;
            RSP_DATA  <= {1'b1, VW'(code)};
          end else if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            RSP_DATA  <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // LED output stage: per-LED mode, blink down-counter and dim level.
  mode_t               mode_r  [LED_COUNT];
  logic [CW-1:0]       cnt_r   [LED_COUNT];
  logic [PWM_BITS-1:0] level_r [LED_COUNT];
  logic [DW-1:0]       div_r   [LED_COUNT];
  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
      LED     <= '0;
      for (int i = 0; i < LED_COUNT; i++) begin
        mode_r[i]  <= FIXED_OFF;
        cnt_r[i]   <= '0;
        level_r[i] <= '0;
        div_r[i]   <= '0;
      end
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      for (int i = 0; i < LED_COUNT; i++) begin
        if (commit && (sh_all || sh_idx == IW'(i))) begin
          // Every selected LED loads the same counter value, so an "all"
          // blink commit leaves them phase-locked.
          mode_r[i]  <= sh_mode;
          div_r[i]   <= sh_div;
          level_r[i] <= sh_level;
          cnt_r[i]   <= reload_tbl[sh_div];
          case (sh_mode)
            FIXED_ON: LED[i] <= 1'b1;
            DIM:      LED[i] <= (pwm_cnt < sh_level);
            default:  LED[i] <= 1'b0;
          endcase
        end else begin
          case (mode_r[i])
            FIXED_ON: LED[i] <= 1'b1;
            BLINK: begin
              if (cnt_r[i] == '0) begin
                LED[i]   <= ~LED[i];
                cnt_r[i] <= reload_tbl[div_r[i]];
              end else begin
                cnt_r[i] <= cnt_r[i] - CW'(1);
              end
            end
            DIM:     LED[i] <= (pwm_cnt < level_r[i]);
            default: LED[i] <= 1'b0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_led_ctrl_ipc.sv
module tb_led_ctrl_ipc;

  localparam int TW = 65;
  typedef logic [TW-1:0] tok_t;

  localparam tok_t T_LED = 65'h6c6564;
  localparam tok_t T_ALL = 65'h616c6c;
  localparam tok_t T_ON  = 65'h6f6e;
  localparam tok_t T_OFF = 65'h6f6666;
  localparam tok_t T_DIM = 65'h64696d;
  localparam tok_t T_X   = 65'h78;
  localparam tok_t EOM   = 65'h0;

  logic        clk;
  logic        reset;
  logic [15:0] LED;
  tok_t        FIFO_DATA;
  logic        FIFO_RD_EN;
  logic        FIFO_EMPTY;
  tok_t        RSP_DATA;
  logic        RSP_VALID;
  logic        RSP_READY;

  led_ctrl_ipc #(
    .LED_COUNT(16), .CLOCK_FREQ(100), .DIVISORS(20), .PWM_BITS(4), .TOKEN_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset), .LED(LED),
    .FIFO_DATA(FIFO_DATA), .FIFO_RD_EN(FIFO_RD_EN), .FIFO_EMPTY(FIFO_EMPTY),
    .RSP_DATA(RSP_DATA), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  tok_t mem [256];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  int   cyc = 0;
  int   v_rsp = 0, v_dbl = 0, v_empty = 0;
  logic prev_rd = 1'b0;

  assign FIFO_EMPTY = (rd_ptr == wr_ptr);

  // Command FIFO model plus read-strobe protocol monitor.
  initial FIFO_DATA = '0;
  always @(posedge clk) begin
    cyc++;
    if (FIFO_RD_EN === 1'b1) begin
      if (RSP_VALID === 1'b1) v_rsp++;
      if (prev_rd) v_dbl++;
      if (rd_ptr == wr_ptr) v_empty++;
      else begin
        FIFO_DATA = mem[rd_ptr % 256];
        rd_ptr++;
      end
    end
    prev_rd = (FIFO_RD_EN === 1'b1);
  end

  function automatic tok_t num(input longint unsigned v);
    return {1'b1, 64'(v)};
  endfunction

  task automatic push(input tok_t t);
    mem[wr_ptr % 256] = t;
    wr_ptr++;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [15:0] led_p1, led_p2;
  int          cyc_v;

  task automatic wait_valid(input string tag, input int code);
    int t;
    t = 0;
    led_p1 = LED;
    led_p2 = LED;
    do begin
      @(negedge clk);
      t++;
      if (RSP_VALID !== 1'b1) begin
        led_p2 = led_p1;
        led_p1 = LED;
      end
    end while (RSP_VALID !== 1'b1 && t < 400);
    cyc_v = cyc;
    check({tag, " rsp_valid"}, 128'(RSP_VALID), 128'(1));
    check({tag, " rsp_data"}, 128'(RSP_DATA), 128'(num(longint'(code))));
  endtask

  task automatic accept(input string tag);
    RSP_READY = 1'b1;
    @(negedge clk);
    RSP_READY = 1'b0;
    check({tag, " rsp_valid drop"}, 128'(RSP_VALID), 128'(0));
  endtask

  task automatic wait_rsp(input string tag, input int code);
    wait_valid(tag, code);
    accept(tag);
  endtask

  task automatic wait_k(input int base, input int k);
    while (cyc - base < k) @(negedge clk);
  endtask

  initial begin
    int   bad, hi, base, t;
    tok_t held;
    reset = 1'b1;
    RSP_READY = 1'b0;
    repeat (3) @(negedge clk);
    check("reset led", 128'(LED), 128'(0));
    check("reset rsp_valid", 128'(RSP_VALID), 128'(0));
    check("reset rsp_data", 128'(RSP_DATA), 128'(0));
    check("reset rd_en", 128'(FIFO_RD_EN), 128'(0));
    reset = 1'b0;
    @(negedge clk);

    // led 3 on
    push(T_LED); push(num(3)); push(T_ON); push(EOM);
    wait_valid("on3", 0);
    check("on3 led before commit", 128'(led_p2[2]), 128'(0));
    check("on3 led after commit", 128'(led_p1[2]), 128'(1));
    accept("on3");
    check("on3 led", 128'(LED), 128'(16'h0004));

    // out-of-range target, then recover
    push(T_LED); push(num(17)); push(T_ON); push(EOM);
    wait_rsp("tgt17", 2);
    check("tgt17 led", 128'(LED), 128'(16'h0004));

    // extra token where EOM expected
    push(T_LED); push(num(2)); push(T_ON); push(T_X); push(EOM);
    wait_rsp("extra", 1);
    check("extra led", 128'(LED), 128'(16'h0004));
    check("extra consumed", 128'(wr_ptr - rd_ptr), 128'(0));

    // boundary and syntax cases
    push(T_LED); push(num(0)); push(T_OFF); push(EOM);
    wait_rsp("tgt0", 2);
    push(T_LED); push(T_ALL); push(num(21)); push(EOM);
    wait_rsp("div21", 2);
    push(T_LED); push(num(1)); push(T_DIM); push(num(16)); push(EOM);
    wait_rsp("lvl16", 2);
    push(T_LED); push(num(1)); push(T_DIM); push(EOM);
    wait_rsp("lvl eom", 1);
    push(T_LED); push(num(3)); push(EOM);
    wait_rsp("arg eom", 1);
    push(T_ON); push(EOM);
    wait_rsp("bad cmd", 1);
    check("errors led", 128'(LED), 128'(16'h0004));

    // lone EOM gives no response; next message is normal
    push(EOM); push(T_LED); push(num(4)); push(T_ON); push(EOM);
    wait_rsp("eom only", 0);
    check("led4 on", 128'(LED), 128'(16'h000c));
    repeat (30) @(negedge clk);
    check("no extra rsp", 128'(RSP_VALID), 128'(0));

    push(T_LED); push(num(4)); push(T_OFF); push(EOM);
    wait_rsp("led4 off", 0);
    check("led4 off led", 128'(LED), 128'(16'h0004));

    // dim with backpressure; a second message waits in the FIFO
    push(T_LED); push(num(1)); push(T_DIM); push(num(4)); push(EOM);
    push(T_LED); push(num(16)); push(T_ON); push(EOM);
    wait_valid("dim", 0);
    held = RSP_DATA;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (RSP_VALID !== 1'b1 || RSP_DATA !== held) bad++;
    end
    check("dim hold stable", 128'(bad), 128'(0));
    check("dim hold pending", 128'(wr_ptr - rd_ptr), 128'(4));
    accept("dim");
    wait_rsp("led16", 0);
    check("led16 on", 128'(LED[15]), 128'(1));
    check("led3 still on", 128'(LED[2]), 128'(1));
    hi = 0;
    repeat (32) begin
      @(negedge clk);
      if (LED[0] === 1'b1) hi++;
    end
    check("dim duty", 128'(hi), 128'(8));

    // blink all with divisor 4: half period 25 cycles
    push(T_LED); push(T_ALL); push(num(4)); push(EOM);
    wait_valid("blink", 0);
    base = cyc_v - 1;
    accept("blink");
    check("blink start", 128'(LED), 128'(16'h0000));
    wait_k(base, 24);
    check("blink k24", 128'(LED), 128'(16'h0000));
    wait_k(base, 25);
    check("blink k25", 128'(LED), 128'(16'hffff));
    wait_k(base, 49);
    check("blink k49", 128'(LED), 128'(16'hffff));
    wait_k(base, 50);
    check("blink k50", 128'(LED), 128'(16'h0000));

    // reset between TARGET and ARG
    push(T_LED); push(num(2));
    t = 0;
    while (wr_ptr != rd_ptr && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset led", 128'(LED), 128'(0));
    check("midreset rsp_valid", 128'(RSP_VALID), 128'(0));
    check("midreset rd_en", 128'(FIFO_RD_EN), 128'(0));
    reset = 1'b0;
    @(negedge clk);
    push(T_ON); push(EOM);
    wait_rsp("after reset", 1);
    check("after reset led", 128'(LED), 128'(0));
    check("after reset consumed", 128'(wr_ptr - rd_ptr), 128'(0));

    check("rd during rsp_valid", 128'(v_rsp), 128'(0));
    check("rd strobe width", 128'(v_dbl), 128'(0));
    check("rd while empty", 128'(v_empty), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
